// File: rtl/contactor_sequencer.sv
// -----------------------------------------------------------------------------
// contactor_sequencer
//
// Command-side controller for the eight-contactor ring (A..H, idx 0..7).
// It takes one open/close command at a time and raises a one-hot close request
// toward the ring interlock. The coil is driven only when the interlock permits.
// The block then waits for debounced auxiliary feedback, bounded by a timeout.
// Coil/feedback disagreement on any channel not currently being switched is
// latched as a fault.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake (ready only in IDLE, not while a
//                           response is being pulsed)
//   i_cmd_idx, i_cmd_close  contactor index and direction (1 = close)
//   o_req                   one-hot close request to the interlock
//   i_permit                interlock permits (1 = allowed)
//   i_fb                    raw asynchronous auxiliary contacts
//   o_fb_stable             synchronised + debounced feedback
//   o_coil                  coil drive
//   o_resp_valid/o_resp_code one-cycle response: 00 ok, 01 denied,
//                           10 timeout, 11 discrepancy
//   o_fault, o_fault_idx    latched fault and offending channel
//   i_fault_clr             fault acknowledge (honoured only once feedback is 0)
// -----------------------------------------------------------------------------
module contactor_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [2:0] i_cmd_idx,
  input  logic       i_cmd_close,
  output logic [7:0] o_req,
  input  logic [7:0] i_permit,
  input  logic [7:0] i_fb,
  output logic [7:0] o_fb_stable,
  output logic [7:0] o_coil,
  output logic       o_resp_valid,
  output logic [1:0] o_resp_code,
  output logic       o_fault,
  output logic [2:0] o_fault_idx,
  input  logic       i_fault_clr
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_DENIED  = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;
  localparam logic [1:0] RESP_DISCREP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_CHECK   = 3'd2,
    S_WAIT_FB = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  // One-hot decode of a contactor index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Index of the lowest set bit (0 when none are set).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        r = 3'(k);
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Feedback synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic [7:0]       sync1_r;
  logic [7:0]       sync2_r;
  logic [7:0]       stable_r;
  logic [CNT_W-1:0] cnt_r [8];

  // Two-flop synchroniser plus per-bit run-length counter; a bit flips only
  // after DEBOUNCE_CYCLES consecutive samples that differ from the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_r  <= 8'h00;
      sync2_r  <= 8'h00;
      stable_r <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= i_fb;
      sync2_r <= sync1_r;
      for (int k = 0; k < 8; k++) begin
        if (sync2_r[k] == stable_r[k]) begin
          cnt_r[k] <= {CNT_W{1'b0}};
        end else if (cnt_r[k] == CNT_LAST) begin
          stable_r[k] <= sync2_r[k];
          cnt_r[k]    <= {CNT_W{1'b0}};
        end else begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t             state_r,      state_s;
  logic [2:0]         idx_r,        idx_s;
  logic               close_r,      close_s;
  logic [7:0]         req_r,        req_s;
  logic [7:0]         coil_r,       coil_s;
  logic [TIMER_W-1:0] timer_r,      timer_s;
  logic               resp_valid_r, resp_valid_s;
  logic [1:0]         resp_code_r,  resp_code_s;
  logic               fault_r,      fault_s;
  logic [2:0]         fault_idx_r,  fault_idx_s;

  logic [7:0] chk_mask_s;
  logic [7:0] mism_s;
  logic       trip_s;
  logic       cmd_ready_s;

  // Discrepancy monitor: the channel being switched is exempt while a command
  // is in flight, because its coil and feedback legitimately disagree then.
  always_comb begin
    chk_mask_s = 8'hFF;
    if (state_r != S_IDLE) begin
      chk_mask_s = ~onehot8(idx_r);
    end else begin
      chk_mask_s = 8'hFF;
    end
    mism_s = (coil_r ^ stable_r) & chk_mask_s;
    trip_s = (state_r != S_FAULT) && (mism_s != 8'h00);
  end

  // Ready is withheld during the response pulse so acceptance starts one
  // IDLE cycle later.
  assign cmd_ready_s = (state_r == S_IDLE) && !resp_valid_r;

  // Next-state and next-output logic; the discrepancy trip outranks every
  // state action, including a same-cycle timeout.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    close_s      = close_r;
    req_s        = 8'h00;
    coil_s       = coil_r;
    timer_s      = timer_r;
    resp_valid_s = 1'b0;
    resp_code_s  = resp_code_r;
    fault_s      = fault_r;
    fault_idx_s  = fault_idx_r;

    if (trip_s) begin
      state_s     = S_FAULT;
      coil_s      = 8'h00;
      fault_s     = 1'b1;
      fault_idx_s = lowest_set(mism_s);
      if (state_r != S_IDLE) begin
        resp_valid_s = 1'b1;
        resp_code_s  = RESP_DISCREP;
      end else begin
        resp_valid_s = 1'b0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_cmd_valid && cmd_ready_s) begin
            idx_s   = i_cmd_idx;
            close_s = i_cmd_close;
            if (i_cmd_close) begin
              req_s = onehot8(i_cmd_idx);
            end else begin
              req_s = 8'h00;
            end
            state_s = S_REQ;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_REQ: begin
          req_s   = req_r;
          state_s = S_CHECK;
        end
        S_CHECK: begin
          if (close_r && !i_permit[idx_r]) begin
            resp_valid_s = 1'b1;
            resp_code_s  = RESP_DENIED;
            state_s      = S_IDLE;
          end else if ((coil_r[idx_r] == close_r) && (stable_r[idx_r] == close_r)) begin
            resp_valid_s = 1'b1;
            resp_code_s  = RESP_OK;
            state_s      = S_IDLE;
          end else begin
            coil_s[idx_r] = close_r;
            timer_s       = {TIMER_W{1'b0}};
            state_s       = S_WAIT_FB;
          end
        end
        S_WAIT_FB: begin
          if (stable_r[idx_r] == close_r) begin
            resp_valid_s = 1'b1;
            resp_code_s  = RESP_OK;
            state_s      = S_IDLE;
          end else if (timer_r >= TIMER_LAST) begin
            timer_s      = TIMER_MAX;
            state_s      = S_FAULT;
            coil_s       = 8'h00;
            fault_s      = 1'b1;
            fault_idx_s  = idx_r;
            resp_valid_s = 1'b1;
            resp_code_s  = RESP_TIMEOUT;
          end else if (timer_r < TIMER_MAX) begin
            timer_s = timer_r + TIMER_W'(1);
          end else begin
            timer_s = TIMER_MAX;
          end
        end
        S_FAULT: begin
          coil_s  = 8'h00;
          fault_s = 1'b1;
          // Leave only once every contactor is confirmed open.
          if (i_fault_clr && (stable_r == 8'h00)) begin
            fault_s = 1'b0;
            state_s = S_IDLE;
          end else begin
            state_s = S_FAULT;
          end
        end
        default: begin
          state_s = S_IDLE;
          coil_s  = 8'h00;
        end
      endcase
    end
  end

  // State and registered-output update; reset drops every coil immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      idx_r        <= 3'd0;
      close_r      <= 1'b0;
      req_r        <= 8'h00;
      coil_r       <= 8'h00;
      timer_r      <= {TIMER_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_code_r  <= 2'b00;
      fault_r      <= 1'b0;
      fault_idx_r  <= 3'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      close_r      <= close_s;
      req_r        <= req_s;
      coil_r       <= coil_s;
      timer_r      <= timer_s;
      resp_valid_r <= resp_valid_s;
      resp_code_r  <= resp_code_s;
      fault_r      <= fault_s;
      fault_idx_r  <= fault_idx_s;
    end
  end

  assign o_cmd_ready  = cmd_ready_s;
  assign o_req        = req_r;
  assign o_fb_stable  = stable_r;
  assign o_coil       = coil_r;
  assign o_resp_valid = resp_valid_r;
  assign o_resp_code  = resp_code_r;
  assign o_fault      = fault_r;
  assign o_fault_idx  = fault_idx_r;

endmodule

// File: tb/tb_contactor_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for contactor_sequencer (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
// Expected responses are queued by the stimulus process; a monitor pops and
// compares whenever o_resp_valid pulses. Timing-sensitive points are checked
// directly, 1 time unit after the relevant rising edge.
// -----------------------------------------------------------------------------
module tb_contactor_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_idx;
  logic       cmd_close;
  logic [7:0] req;
  logic [7:0] permit;
  logic [7:0] fb;
  logic [7:0] fb_stable;
  logic [7:0] coil;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic       fault;
  logic [2:0] fault_idx;
  logic       fault_clr;

  typedef struct packed {
    logic [1:0] code;
    logic       flt;
    logic       chk_idx;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  contactor_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_idx    (cmd_idx),
    .i_cmd_close  (cmd_close),
    .o_req        (req),
    .i_permit     (permit),
    .i_fb         (fb),
    .o_fb_stable  (fb_stable),
    .o_coil       (coil),
    .o_resp_valid (resp_valid),
    .o_resp_code  (resp_code),
    .o_fault      (fault),
    .o_fault_idx  (fault_idx),
    .i_fault_clr  (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got code=%b fault=%b idx=%0d, required no pulse",
                 resp_code, fault, fault_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (resp_code !== e.code || fault !== e.flt ||
            (e.chk_idx && fault_idx !== e.idx)) begin
          bad++;
          $display("FAIL resp: got code=%b fault=%b idx=%0d, required code=%b fault=%b idx=%0d",
                   resp_code, fault, fault_idx, e.code, e.flt, e.idx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] code, input logic flt,
                          input logic chk_idx, input logic [2:0] idx);
    exp_t e;
    e.code    = code;
    e.flt     = flt;
    e.chk_idx = chk_idx;
    e.idx     = idx;
    exp_q.push_back(e);
  endtask

  // Issue a command; returns 1 time unit after the accepting edge T.
  task automatic send(input logic [2:0] idx, input logic close);
    chk("ready_before_cmd", {7'd0, cmd_ready}, 8'h01);
    cmd_idx   = idx;
    cmd_close = close;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: ready still %b after %0d cycles, required 1", name, cmd_ready, budget);
    end
  endtask

  task automatic clear_fault(input string name, input int budget);
    int n;
    n = 0;
    fault_clr = 1'b1;
    while (fault !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    fault_clr = 1'b0;
    chk(name, {7'd0, fault}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_idx   = 3'd0;
    cmd_close = 1'b0;
    permit    = 8'hFF;
    fb        = 8'h00;
    fault_clr = 1'b0;
    tick(3);
    chk("rst_ready", {7'd0, cmd_ready}, 8'h01);
    chk("rst_coil", coil, 8'h00);
    chk("rst_req", req, 8'h00);
    chk("rst_fb_stable", fb_stable, 8'h00);
    chk("rst_misc", {2'd0, resp_valid, resp_code, fault, 2'd0}, 8'h00);
    chk("rst_fault_idx", {5'd0, fault_idx}, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // 1: close C, feedback arrives 3 cycles after the coil
    push_exp(2'b00, 1'b0, 1'b0, 3'd0);
    send(3'd2, 1'b1);
    chk("c_req_t1", req, 8'h04);
    tick(1);
    chk("c_req_t2", req, 8'h04);
    chk("c_coil_before", coil, 8'h00);
    tick(1);
    chk("c_req_after", req, 8'h00);
    chk("c_coil", coil, 8'h04);
    tick(3);
    fb = 8'h04;
    wait_ready("c_done", 30);
    chk("c_coil_end", coil, 8'h04);
    chk("c_fb_stable", fb_stable, 8'h04);
    chk("c_fault", {7'd0, fault}, 8'h00);

    // 2: close A denied
    permit = 8'hFE;
    push_exp(2'b01, 1'b0, 1'b0, 3'd0);
    send(3'd0, 1'b1);
    tick(2);
    chk("a_pulse_t2", {7'd0, resp_valid}, 8'h01);
    chk("a_coil", coil, 8'h04);
    wait_ready("a_done", 5);
    chk("a_fault", {7'd0, fault}, 8'h00);
    permit = 8'hFF;

    // 3: close H, feedback never rises -> timeout after 20 WAIT_FB cycles
    push_exp(2'b10, 1'b1, 1'b1, 3'd7);
    send(3'd7, 1'b1);
    tick(2);
    chk("h_coil", coil, 8'h84);
    tick(19);
    chk("h_no_fault_yet", {7'd0, fault}, 8'h00);
    tick(1);
    chk("h_pulse", {7'd0, resp_valid}, 8'h01);
    chk("h_fault", {7'd0, fault}, 8'h01);
    chk("h_coil_off", coil, 8'h00);
    chk("h_fault_idx", {5'd0, fault_idx}, 8'h07);
    chk("h_not_ready", {7'd0, cmd_ready}, 8'h00);
    // C feedback still stable high, so the acknowledge must not release yet
    fb        = 8'h00;
    fault_clr = 1'b1;
    tick(1);
    chk("h_clr_blocked", {7'd0, fault}, 8'h01);
    clear_fault("h_clr", 20);
    chk("h_fb_zero", fb_stable, 8'h00);
    chk("h_idx_held", {5'd0, fault_idx}, 8'h07);
    wait_ready("h_idle", 3);

    // 4: B closed, feedback drops for 6 cycles in IDLE -> silent code-11 fault
    push_exp(2'b00, 1'b0, 1'b0, 3'd0);
    send(3'd1, 1'b1);
    tick(2);
    fb = 8'h02;
    wait_ready("b_done", 30);
    fb = 8'h00;
    tick(6);
    fb = 8'h02;
    tick(1);
    chk("b_disc_fault", {7'd0, fault}, 8'h01);
    chk("b_disc_idx", {5'd0, fault_idx}, 8'h01);
    chk("b_disc_coil", coil, 8'h00);
    fb = 8'h00;
    clear_fault("b_clr", 10);
    chk("b_idx_held", {5'd0, fault_idx}, 8'h01);
    wait_ready("b_idle", 3);
    // re-close B, then a 3-cycle glitch must be absorbed
    push_exp(2'b00, 1'b0, 1'b0, 3'd0);
    send(3'd1, 1'b1);
    tick(2);
    fb = 8'h02;
    wait_ready("b2_done", 30);
    fb = 8'h00;
    tick(3);
    fb = 8'h02;
    tick(10);
    chk("glitch_no_fault", {7'd0, fault}, 8'h00);
    chk("glitch_fb", fb_stable, 8'h02);

    // 5: open already-open D -> immediate ok, then reset during WAIT_FB
    push_exp(2'b00, 1'b0, 1'b0, 3'd0);
    send(3'd3, 1'b0);
    chk("d_req", req, 8'h00);
    tick(2);
    chk("d_pulse_t2", {7'd0, resp_valid}, 8'h01);
    chk("d_coil", coil, 8'h02);
    wait_ready("d_done", 5);
    send(3'd4, 1'b1);
    tick(2);
    chk("e_coil", coil, 8'h12);
    tick(3);
    rst_n = 1'b0;
    fb    = 8'h00;
    #1;
    chk("e_rst_coil", coil, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("e_rst_ready", {7'd0, cmd_ready}, 8'h01);

    // 6: timeout on F coincides with discrepancy on B -> code 11, idx 1
    push_exp(2'b00, 1'b0, 1'b0, 3'd0);
    send(3'd1, 1'b1);
    tick(2);
    fb = 8'h02;
    wait_ready("b3_done", 30);
    push_exp(2'b11, 1'b1, 1'b1, 3'd1);
    send(3'd5, 1'b1);
    tick(15);
    fb = 8'h00;
    tick(6);
    chk("sim_no_fault_yet", {7'd0, fault}, 8'h00);
    chk("sim_fb_fell", fb_stable, 8'h00);
    tick(1);
    chk("sim_fault", {7'd0, fault}, 8'h01);
    chk("sim_idx", {5'd0, fault_idx}, 8'h01);
    chk("sim_pulse", {7'd0, resp_valid}, 8'h01);
    clear_fault("sim_clr", 10);

    tick(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL resp_missing: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
